// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: byte/half/word access with read-modify-write sub-word stores
// Optional feature macro: LSU_BOUND_CHK_EN (addresses >= 128 are rejected as errors)
module lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] Mem_addr,
  output logic [31:0] Mem_w_data,
  output logic        Mem_w,
  output logic        Mem_r,
  input  logic [31:0] Mem_r_data
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        we_q;
  logic        uns_q;
  logic        req_bad;

  // Pick the addressed byte/half out of a memory word and extend it
  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] lane,
                                               input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   return uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  // Replace the target lane(s) of the read word with the new store data
  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [1:0] lane,
                                              input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] r;
    r = w;
    if (size == 2'b00)
      r[{lane, 3'b000} +: 8] = wd[7:0];
    else if (lane[1])
      r[31:16] = wd[15:0];
    else
      r[15:0] = wd[15:0];
    return r;
  endfunction

  // Misalignment / reserved-size / optional bounds check on the incoming request
  always_comb begin
    req_bad = (req_size == 2'b11) ||
              (req_size == 2'b01 && req_addr[0]) ||
              (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`ifdef LSU_BOUND_CHK_EN
    if (req_addr >= 32'd128) req_bad = 1'b1;
`else
    req_bad = req_bad;
`endif
  end

  // Control FSM; every output is registered and defaults to zero each cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= 32'd0;
      Mem_addr   <= 32'd0;
      Mem_w_data <= 32'd0;
      Mem_w      <= 1'b0;
      Mem_r      <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      size_q     <= 2'b00;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
    end else begin
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= 32'd0;
      Mem_addr   <= 32'd0;
      Mem_w_data <= 32'd0;
      Mem_w      <= 1'b0;
      Mem_r      <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            size_q  <= req_size;
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            if (req_bad) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else if (!req_we || req_size != 2'b10) begin
              // loads and sub-word stores both start with a read
              state    <= RD;
              Mem_r    <= 1'b1;
              Mem_addr <= {req_addr[31:2], 2'b00};
            end else begin
              state      <= WR;
              Mem_w      <= 1'b1;
              Mem_addr   <= {req_addr[31:2], 2'b00};
              Mem_w_data <= req_wdata;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        RD: begin
          if (!we_q) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= load_extract(Mem_r_data, addr_q[1:0], size_q, uns_q);
          end else begin
            state      <= WR;
            Mem_w      <= 1'b1;
            Mem_addr   <= {addr_q[31:2], 2'b00};
            Mem_w_data <= store_merge(Mem_r_data, addr_q[1:0], size_q, wdata_q);
          end
        end
        WR: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - self-checking bench for lsu with byte-level memory reference model
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] Mem_addr;
  logic [31:0] Mem_w_data;
  logic        Mem_w;
  logic        Mem_r;
  logic [31:0] Mem_r_data;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [0:255];
  logic [7:0] ref_mem [0:255];

  lsu dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .Mem_addr(Mem_addr), .Mem_w_data(Mem_w_data), .Mem_w(Mem_w), .Mem_r(Mem_r),
    .Mem_r_data(Mem_r_data)
  );

  always #5 clk = ~clk;

  logic [7:0] ma;
  assign ma = Mem_addr[7:0];
  assign Mem_r_data = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};

  always @(posedge clk) begin
    if (Mem_w) begin
      mem[ma]         <= Mem_w_data[7:0];
      mem[ma + 8'd1]  <= Mem_w_data[15:8];
      mem[ma + 8'd2]  <= Mem_w_data[23:16];
      mem[ma + 8'd3]  <= Mem_w_data[31:24];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [7:0] a);
    logic [7:0] b;
    b = {a[7:2], 2'b00};
    return {ref_mem[b + 8'd3], ref_mem[b + 8'd2], ref_mem[b + 8'd1], ref_mem[b]};
  endfunction

  // One request end to end: model prediction, handshake, bus observation, response check
  task automatic do_op(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, output logic [31:0] rdata);
    logic        exp_err;
    logic [31:0] exp_rdata, exp_wword;
    int          exp_lat, exp_rd, exp_wr, nbytes, n, nrd, nwr, k;
    logic [7:0]  a;
    a = addr[7:0];
    exp_err = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
`ifdef LSU_BOUND_CHK_EN
    if (addr >= 32'd128) exp_err = 1'b1;
`endif
    nbytes = 1 << size;
    exp_rdata = 32'd0;
    exp_wword = 32'd0;
    if (exp_err) begin
      exp_lat = 1; exp_rd = 0; exp_wr = 0;
    end else if (!we) begin
      for (int i = 0; i < nbytes; i++) exp_rdata |= 32'(ref_mem[a + 8'(i)]) << (8 * i);
      if (!uns && size == 2'b00) exp_rdata = {{24{exp_rdata[7]}}, exp_rdata[7:0]};
      if (!uns && size == 2'b01) exp_rdata = {{16{exp_rdata[15]}}, exp_rdata[15:0]};
      exp_lat = 2; exp_rd = 1; exp_wr = 0;
    end else begin
      for (int i = 0; i < nbytes; i++) ref_mem[a + 8'(i)] = 8'(wdata >> (8 * i));
      exp_wword = ref_word(a);
      exp_lat = (size == 2'b10) ? 2 : 3;
      exp_rd  = (size == 2'b10) ? 0 : 1;
      exp_wr  = 1;
    end

    @(negedge clk);
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("req_ready_before_accept", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;

    n = 0; nrd = 0; nwr = 0;
    do begin
      @(negedge clk);
      n++;
      check("req_ready_busy", 32'(req_ready), 32'd0);
      check("mem_r_and_w", 32'(Mem_r & Mem_w), 32'd0);
      if (Mem_r) begin
        nrd++;
        check("mem_addr_rd", Mem_addr, {addr[31:2], 2'b00});
      end
      if (Mem_w) begin
        nwr++;
        check("mem_addr_wr", Mem_addr, {addr[31:2], 2'b00});
        check("mem_w_data", Mem_w_data, exp_wword);
      end
      if (!Mem_r && !Mem_w) check("mem_bus_idle", Mem_addr | Mem_w_data, 32'd0);
      if (!rsp_valid) check("rsp_idle_zero", rsp_rdata | 32'(rsp_err), 32'd0);
    end while (!rsp_valid && n < 8);
    check("rsp_latency", 32'(n), 32'(exp_lat));
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("mem_r_cycles", 32'(nrd), 32'(exp_rd));
    check("mem_w_cycles", 32'(nwr), 32'(exp_wr));
    rdata = rsp_rdata;
    @(negedge clk);
    check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    logic [1:0]  sz;
    int          k, mism;

    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end

    #12;
    check("reset_ready", 32'(req_ready), 32'd0);
    check("reset_rsp", 32'(rsp_valid) | 32'(rsp_err) | rsp_rdata, 32'd0);
    check("reset_mem", 32'(Mem_r) | 32'(Mem_w) | Mem_addr | Mem_w_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h8899AABB, r);
    do_op(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, r);
    check("lw_0x10", r, 32'h8899AABB);
    do_op(1'b0, 2'b00, 1'b0, 32'h13, 32'd0, r);
    check("lb_0x13", r, 32'hFFFFFF88);
    do_op(1'b0, 2'b00, 1'b1, 32'h13, 32'd0, r);
    check("lbu_0x13", r, 32'h00000088);
    do_op(1'b0, 2'b01, 1'b0, 32'h12, 32'd0, r);
    check("lh_0x12", r, 32'hFFFF8899);
    do_op(1'b0, 2'b01, 1'b1, 32'h10, 32'd0, r);
    check("lhu_0x10", r, 32'h0000AABB);
    do_op(1'b1, 2'b00, 1'b0, 32'h11, 32'h12345677, r);
    do_op(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, r);
    check("lw_after_sb", r, 32'h889977BB);
    do_op(1'b0, 2'b01, 1'b0, 32'h11, 32'd0, r);
    do_op(1'b1, 2'b10, 1'b0, 32'h12, 32'h0BADF00D, r);
    do_op(1'b0, 2'b11, 1'b0, 32'h20, 32'd0, r);
    do_op(1'b0, 2'b10, 1'b0, 32'h80, 32'd0, r);

    // Reset in the write phase of a half store: access aborted, no response
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h22; req_wdata = 32'h0000CAFE;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!Mem_w && k < 6);
    check("sh_reached_wr", 32'(Mem_w), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mem_w", 32'(Mem_w) | 32'(Mem_r), 32'd0);
    check("rst_mem_bus", Mem_addr | Mem_w_data, 32'd0);
    check("rst_rsp", 32'(rsp_valid) | 32'(rsp_err) | rsp_rdata | 32'(req_ready), 32'd0);
    @(negedge clk);
    check("rst_held_rsp", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("ready_after_release", 32'(req_ready), 32'd1);
    check("no_rsp_after_abort", 32'(rsp_valid), 32'd0);
    do_op(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, r);

    for (int t = 0; t < 60; t++) begin
      sz = 2'($urandom_range(0, 3));
      if (sz == 2'b11 && $urandom_range(0, 3) != 0) sz = 2'b10;
      do_op(1'($urandom), sz, 1'($urandom), 32'($urandom_range(0, 127)), $urandom, r);
    end

    mism = 0;
    for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) mism++;
    check("mem_final_bytes", 32'(mism), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
